write_beat_packer: RTL and testbench

- Downstream of the operations stage, upstream of the MIG write-data path.
- Packs the (16*P)-bit chunk stream (ivalid/istart/ilast) into 512-bit DDR beats.
- Buffers beats in a small FIFO under MIG backpressure and emits wdata/wvalid with beat-level start/last markers.
- Checks the received element count against the programmed message size.

---
 rtl/write_pkg.sv | 25 ++
 rtl/beat_fifo.sv | 51 +++++
 rtl/write_beat_packer.sv | 157 +++++++++++++++
 tb/tb_write_beat_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_pkg.sv
// Shared types and constants for the write-beat packer: beat geometry,
// packer FSM states and the beat FIFO entry layout.
package write_pkg;

  localparam int BEAT_W = 512;
  localparam int ELEM_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              start;
    logic              last;
  } beat_t;

  // Number of (ELEM_W*p)-bit chunks that make up one DDR beat.
  function automatic int chunks_per_beat(input int p);
    return BEAT_W / (ELEM_W * p);
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// Show-ahead synchronous FIFO of DDR beats; head is valid whenever !empty.
// A push while full is taken only if a pop happens in the same cycle.
module beat_fifo
  import write_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   ui_clk,
  input  logic                   aresetn,
  input  logic                   push,
  input  beat_t                  din,
  input  logic                   pop,
  output beat_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge ui_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the top gates the head with !empty.
  always_ff @(posedge ui_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/write_beat_packer.sv
// Packs (16*P)-bit chunks into 512-bit DDR beats, queues them for the MIG
// write path and checks the received element count against the message size.
module write_beat_packer
  import write_pkg::*;
#(
  parameter int P     = 8,
  parameter int DEPTH = 4,
  parameter int MSW   = 16
) (
  input  logic              ui_clk,
  input  logic              aresetn,
  input  logic [MSW-1:0]    messagesize,
  input  logic              msvalid,
  input  logic [16*P-1:0]   idata,
  input  logic              ivalid,
  output logic              iready,
  input  logic              istart,
  input  logic              ilast,
  output logic [511:0]      wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wstart,
  output logic              wlast,
  output logic [MSW-1:0]    beats,
  output logic              err,
  input  logic              clr_err
);

  localparam int CW = ELEM_W * P;
  localparam int C  = chunks_per_beat(P);
  localparam int SW = (C > 1) ? $clog2(C) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(C - 1);

  state_t               state, nstate;
  logic [SW-1:0]        slot, slot_n, fill_slot;
  logic                 first, first_n;
  logic [C-1:0][CW-1:0] pack_q, pack_n, filled;
  logic [MSW-1:0]       size_q;
  logic [MSW-1:0]       elems, elems_n;
  logic                 accept, start_msg, err_set, push, pop;
  beat_t                push_beat, head;
  logic                 full, empty;
  logic [AW:0]          fifo_count;

  assign iready = aresetn && (state != FLUSH) && (fifo_count != (AW+1)'(DEPTH));
  assign accept = ivalid && iready;

  assign wvalid = !empty;
  assign wdata  = empty ? '0 : head.data;
  assign wstart = !empty && head.start;
  assign wlast  = !empty && head.last;
  assign pop    = wvalid && wready;

  // Beat image after writing this chunk: lower slots kept, higher slots
  // zeroed, so a restart discards stale data and a short tail is zero-filled.
  always_comb begin
    fill_slot = istart ? '0 : slot;
    filled    = '0;
    for (int k = 0; k < C; k++) begin
      if (k < int'(fill_slot))       filled[k] = pack_q[k];
      else if (k == int'(fill_slot)) filled[k] = idata;
    end
  end

  always_comb begin
    nstate          = state;
    slot_n          = slot;
    first_n         = first;
    pack_n          = pack_q;
    elems_n         = elems;
    start_msg       = 1'b0;
    err_set         = 1'b0;
    push            = 1'b0;
    push_beat.data  = filled;
    push_beat.start = istart || first;
    push_beat.last  = ilast;
    unique case (state)
      IDLE, PACK: begin
        if (accept) begin
          if (!istart && state == IDLE) begin
            err_set = 1'b1;
          end else begin
            if (istart) begin
              start_msg = 1'b1;
              first_n   = 1'b1;
              err_set   = (state == PACK);
              elems_n   = MSW'(P);
            end else begin
              elems_n   = elems + MSW'(P);
            end
            pack_n = filled;
            if (ilast && elems_n != size_q) err_set = 1'b1;
            if (fill_slot == LAST_SLOT) begin
              push    = 1'b1;
              first_n = 1'b0;
              slot_n  = '0;
              nstate  = ilast ? IDLE : PACK;
            end else begin
              slot_n  = fill_slot + 1'b1;
              nstate  = ilast ? FLUSH : PACK;
            end
          end
        end
      end
      FLUSH: begin
        if (!full) begin
          push            = 1'b1;
          push_beat.data  = pack_q;
          push_beat.start = first;
          push_beat.last  = 1'b1;
          first_n         = 1'b0;
          nstate          = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      slot   <= '0;
      first  <= 1'b0;
      pack_q <= '0;
      size_q <= '0;
      elems  <= '0;
      beats  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= nstate;
      slot   <= slot_n;
      first  <= first_n;
      pack_q <= pack_n;
      elems  <= elems_n;
      if (msvalid && state == IDLE) size_q <= messagesize;
      if (start_msg)  beats <= MSW'(push);
      else if (push)  beats <= beats + 1'b1;
      // A same-cycle set outranks the clear.
      if (err_set)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

  beat_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ui_clk  (ui_clk),
    .aresetn (aresetn),
    .push    (push),
    .din     (push_beat),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_write_beat_packer.sv
// Directed bench for write_beat_packer: queue-based reference of the beat
// stream plus literal checks of selected beats, counters and the error flag.
module tb_write_beat_packer;

  localparam int P   = 8;
  localparam int MSW = 16;
  localparam int CW  = 16 * P;
  localparam int C   = 512 / CW;

  logic            ui_clk = 0;
  logic            aresetn;
  logic [MSW-1:0]  messagesize;
  logic            msvalid;
  logic [CW-1:0]   idata;
  logic            ivalid, iready, istart, ilast;
  logic [511:0]    wdata;
  logic            wvalid, wready, wstart, wlast;
  logic [MSW-1:0]  beats;
  logic            err, clr_err;

  write_beat_packer #(.P(P), .DEPTH(4), .MSW(MSW)) dut (
    .ui_clk(ui_clk), .aresetn(aresetn), .messagesize(messagesize), .msvalid(msvalid),
    .idata(idata), .ivalid(ivalid), .iready(iready), .istart(istart), .ilast(ilast),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wstart(wstart), .wlast(wlast),
    .beats(beats), .err(err), .clr_err(clr_err)
  );

  always #5 ui_clk = ~ui_clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [511:0] d; logic s; logic l; } beat_s;
  beat_s         expq[$];
  beat_s         cap[$];
  logic [CW-1:0] cur[$];
  bit            in_msg, m_first, m_err, set_e;
  int            m_elems, acc;
  logic [MSW-1:0] m_size, m_beats;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int base, input int i);
    logic [CW-1:0] r;
    for (int e = 0; e < P; e++) r[e*16 +: 16] = 16'(base + i*P + e);
    return r;
  endfunction

  task automatic model_clear();
    expq.delete(); cur.delete();
    in_msg = 0; m_first = 0; m_err = 0; m_elems = 0; m_size = '0; m_beats = '0;
  endtask

  // Reference: beats are formed from whole messages' chunk lists; the DUT
  // stream is compared at every handshake, regardless of its timing.
  always @(negedge ui_clk) begin
    if (aresetn) begin
      if (wvalid && wready) begin
        beat_s a;
        a.d = wdata; a.s = wstart; a.l = wlast;
        cap.push_back(a);
        if (expq.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          beat_s e;
          e = expq.pop_front();
          chk("wdata", wdata, e.d);
          chk("wstart", wstart, e.s);
          chk("wlast", wlast, e.l);
        end
      end
      set_e = 0;
      if (msvalid && !in_msg) m_size = messagesize;
      if (ivalid && iready) begin
        acc++;
        if (istart) begin
          if (in_msg) set_e = 1;
          cur.delete(); in_msg = 1; m_first = 1; m_elems = 0; m_beats = '0;
        end
        if (!in_msg) set_e = 1;
        else begin
          cur.push_back(idata);
          m_elems += P;
          if (cur.size() == C || ilast) begin
            beat_s b;
            b.d = '0;
            for (int k = 0; k < cur.size(); k++) b.d[k*CW +: CW] = cur[k];
            b.s = m_first; b.l = ilast;
            expq.push_back(b);
            m_beats++; m_first = 0; cur.delete();
          end
          if (ilast) begin
            if (MSW'(m_elems) != m_size) set_e = 1;
            in_msg = 0;
          end
        end
      end
      if (set_e) m_err = 1;
      else if (clr_err) m_err = 0;
    end
  end

  task automatic send_chunk(input logic [CW-1:0] d, input bit s, input bit l);
    int n = 0;
    idata = d; istart = s; ilast = l; ivalid = 1;
    @(negedge ui_clk);
    while (!iready && n < 200) begin @(negedge ui_clk); n++; end
    if (!iready) chk("accept_timeout", 0, 1);
    @(posedge ui_clk); #1;
    ivalid = 0; istart = 0; ilast = 0;
  endtask

  task automatic send_msg(input int base, input int n, input bit s, input bit l);
    @(posedge ui_clk); #1;
    for (int i = 0; i < n; i++) send_chunk(mk(base, i), s && i == 0, l && i == n-1);
  endtask

  task automatic set_size(input int sz);
    @(posedge ui_clk); #1;
    messagesize = MSW'(sz); msvalid = 1;
    @(posedge ui_clk); #1;
    msvalid = 0;
  endtask

  task automatic pulse_clr();
    @(posedge ui_clk); #1; clr_err = 1;
    @(posedge ui_clk); #1; clr_err = 0;
    @(negedge ui_clk);
  endtask

  task automatic drain();
    int n = 0;
    repeat (4) @(negedge ui_clk);
    while ((wvalid || expq.size() != 0) && n < 500) begin @(negedge ui_clk); n++; end
    chk("drain", (wvalid || expq.size() != 0), 0);
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_beats"}, beats, m_beats);
    chk({nm, "_err"}, err, m_err);
  endtask

  initial begin
    int a0;
    aresetn = 0; messagesize = '0; msvalid = 0; idata = '0; ivalid = 0;
    istart = 0; ilast = 0; wready = 1; clr_err = 0;
    model_clear(); acc = 0;
    repeat (2) @(negedge ui_clk);
    chk("rst_iready", iready, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstart", wstart, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_beats", beats, 0);
    chk("rst_err", err, 0);
    #2 aresetn = 1;

    // Full 1024-element message, no backpressure.
    set_size(1024); cap.delete();
    send_msg(16'h1000, 128, 1, 1);
    drain();
    chk("t1_nbeats", cap.size(), 32);
    chk("t1_first_start", cap[0].s, 1);
    chk("t1_last", cap[31].l, 1);
    chk("t1_slot0", cap[0].d[127:0], 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    chk("t1_beats", beats, 32);
    chk("t1_err", err, 0);

    // 40 elements: one full beat and a zero-filled tail beat.
    set_size(40); cap.delete();
    send_msg(16'h2000, 5, 1, 1);
    drain();
    chk("t2_nbeats", cap.size(), 2);
    chk("t2_tail_lo", cap[1].d[127:0], 128'h2027_2026_2025_2024_2023_2022_2021_2020);
    chk("t2_tail_hi", cap[1].d[511:128], 0);
    chk("t2_tail_last", cap[1].l, 1);
    chk("t2_beats", beats, 2);
    chk("t2_err", err, 0);

    // MIG backpressure for 30 cycles.
    set_size(1024); cap.delete();
    @(posedge ui_clk); #1 wready = 0;
    a0 = acc;
    fork
      send_msg(16'h3000, 128, 1, 1);
      begin
        repeat (30) @(negedge ui_clk);
        chk("t3_iready_low", iready, 0);
        chk("t3_wvalid", wvalid, 1);
        chk("t3_accepted", acc - a0, 16);
        @(posedge ui_clk); #1 wready = 1;
      end
    join
    drain();
    chk("t3_nbeats", cap.size(), 32);
    chk_state("t3");

    // Short message: length error, still one wlast beat.
    set_size(64); cap.delete();
    send_msg(16'h9000, 6, 1, 1);
    drain();
    chk("t4_nbeats", cap.size(), 2);
    chk("t4_b0_last", cap[0].l, 0);
    chk("t4_b1_last", cap[1].l, 1);
    chk("t4_err", err, 1);
    pulse_clr();
    chk("t4_err_clr", err, 0);

    // istart re-asserted on the third chunk.
    set_size(32); cap.delete();
    @(posedge ui_clk); #1;
    send_chunk(mk(16'h3500, 0), 1, 0);
    send_chunk(mk(16'h3500, 1), 0, 0);
    send_msg(16'h4000, 4, 1, 1);
    drain();
    chk("t5_nbeats", cap.size(), 1);
    chk("t5_start", cap[0].s, 1);
    chk("t5_slot0", cap[0].d[127:0], 128'h4007_4006_4005_4004_4003_4002_4001_4000);
    chk("t5_err", err, 1);
    chk_state("t5");
    pulse_clr();

    // Reset with three beats queued and a partial beat in flight.
    set_size(1024);
    @(posedge ui_clk); #1 wready = 0;
    send_msg(16'h6000, 14, 1, 0);
    @(negedge ui_clk);
    chk("t6_queued", wvalid, 1);
    #2 aresetn = 0;
    #1;
    chk("t6_rst_wvalid", wvalid, 0);
    chk("t6_rst_beats", beats, 0);
    chk("t6_rst_wdata", wdata, 0);
    model_clear(); cap.delete();
    @(negedge ui_clk); #2;
    aresetn = 1; wready = 1;

    set_size(8);
    send_msg(16'h5000, 1, 1, 1);
    drain();
    chk("t6_single_n", cap.size(), 1);
    chk("t6_single_se", {cap[0].s, cap[0].l}, 2'b11);
    chk("t6_single_data", cap[0].d, {384'h0, 128'h5007_5006_5005_5004_5003_5002_5001_5000});
    chk("t6_single_beats", beats, 1);
    chk("t6_single_err", err, 0);

    set_size(64); cap.delete();
    send_msg(16'h7000, 8, 1, 1);
    drain();
    chk("t6_two_n", cap.size(), 2);
    chk_state("t6_two");

    // Chunk without istart while idle is dropped and flags an error.
    cap.delete();
    send_msg(16'h8000, 1, 0, 0);
    drain();
    chk("t7_dropped", cap.size(), 0);
    chk("t7_err", err, 1);
    chk_state("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
